pwm_stage: RTL and testbench

- Output stage downstream of an anspwm modulator: consumes its 16-bit val_out and produces a single-bit PWM waveform for a pin or LED.
- Values arrive on a valid/ready handshake into a shadow register. They transfer to the active duty register only at period boundaries, so the waveform never glitches mid-period.
- Duty resolution is CNT_W bits. The optional dither feature recovers the truncated low bits by first-order noise shaping across periods.

---
 rtl/pwm_stage.sv | 132 +++++++++++++
 tb/tb_pwm_stage.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_stage.sv
`default_nettype none
// ============================================================================
// Module      : pwm_stage
// Description : PWM output stage fed by a modulator value stream. Values are
//               accepted on a valid/ready handshake into a shadow register and
//               move to the active duty register only at period boundaries,
//               so a period is never altered once it has started.
//               Optional macro PWM_DITHER_EN adds first-order noise shaping
//               of the truncated low value bits across periods.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_stage #(
  parameter int VAL_W = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk_in,
  input  logic             rstn_in,
  input  logic             enable,
  input  logic [VAL_W-1:0] val_in,
  input  logic             val_valid,
  output logic             val_ready,
  output logic             pwm_out,
  output logic             frame_start,
  output logic [CNT_W:0]   duty_q
);

  localparam int             C_R_W     = VAL_W - CNT_W;
  localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
  localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;
  logic [VAL_W-1:0] r_shadow;
  logic [VAL_W-1:0] r_active;
  logic             r_full;
  logic             r_pwm;
  logic             r_frame;
  logic [CNT_W:0]   r_duty;

  logic             w_boundary;
  logic             w_accept;
  logic             w_load;
  logic [VAL_W-1:0] w_active_new;
  logic [CNT_W-1:0] w_duty_top;
  logic [CNT_W:0]   w_duty_eff;

  // Boundary: last count of an enabled period, or every cycle while idle so
  // new values still reach the duty register before the first period.
  assign w_boundary   = !enable || (r_cnt == C_CNT_MAX);
  assign w_accept     = val_valid && !r_full;
  assign w_load       = w_boundary && r_full;
  assign w_active_new = w_load ? r_shadow : r_active;
  assign w_duty_top   = w_active_new[VAL_W-1 -: CNT_W];

  assign val_ready   = !r_full;
  assign pwm_out     = r_pwm;
  assign frame_start = r_frame;
  assign duty_q      = r_duty;

`ifdef PWM_DITHER_EN
  logic [C_R_W-1:0] r_acc;
  logic [C_R_W:0]   w_sum;
  logic             w_carry;

  // Residue accumulates only on enabled boundaries; the carry adds one count.
  assign w_sum      = {1'b0, r_acc} + {1'b0, w_active_new[C_R_W-1:0]};
  assign w_carry    = enable && w_sum[C_R_W];
  assign w_duty_eff = {1'b0, w_duty_top} + (CNT_W+1)'(w_carry);

  // Noise-shaping accumulator, held while the counter is idle.
  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) begin
      r_acc <= '0;
    end else if (w_boundary && enable) begin
      r_acc <= w_sum[C_R_W-1:0];
    end
  end
`else
  logic w_unused_low;

  // Low bits are truncated; the reduction only marks them as intentionally dropped.
  assign w_unused_low = ^w_active_new[C_R_W-1:0];
  assign w_duty_eff   = {1'b0, w_duty_top};
`endif

  // Shadow register and its occupancy flag (accept and load never coincide).
  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) begin
      r_shadow <= '0;
      r_full   <= 1'b0;
    end else if (w_accept) begin
      r_shadow <= val_in;
      r_full   <= 1'b1;
    end else if (w_load) begin
      r_full   <= 1'b0;
    end
  end

  // Active value and registered effective duty update only at boundaries.
  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) begin
      r_active <= '0;
      r_duty   <= '0;
    end else if (w_boundary) begin
      r_active <= w_active_new;
      r_duty   <= w_duty_eff;
    end
  end

  // Period counter: free-running when enabled, parked at zero when idle.
  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) begin
      r_cnt <= '0;
    end else if (enable) begin
      r_cnt <= r_cnt + C_CNT_ONE;
    end else begin
      r_cnt <= '0;
    end
  end

  // Registered waveform and frame marker, one clock behind the counter.
  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) begin
      r_pwm   <= 1'b0;
      r_frame <= 1'b0;
    end else begin
      r_pwm   <= enable && ({1'b0, r_cnt} < r_duty);
      r_frame <= enable && (r_cnt == '0);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pwm_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm_stage
// Description : Self-checking bench for pwm_stage: table of steady-state duty
//               values plus directed sequences for handshake back-pressure,
//               dither, asynchronous reset and idle operation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_stage;

  localparam int VAL_W = 16;
  localparam int CNT_W = 8;
  localparam int PERIOD = 256;

  logic             clk_in = 1'b0;
  logic             rstn_in;
  logic             enable;
  logic [VAL_W-1:0] val_in;
  logic             val_valid;
  logic             val_ready;
  logic             pwm_out;
  logic             frame_start;
  logic [CNT_W:0]   duty_q;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [VAL_W-1:0] val;
    int               exp_hi;
    int               exp_duty;
  } vec_t;

  vec_t vecs [6];

  pwm_stage #(.VAL_W(VAL_W), .CNT_W(CNT_W)) dut (
    .clk_in      (clk_in),
    .rstn_in     (rstn_in),
    .enable      (enable),
    .val_in      (val_in),
    .val_valid   (val_valid),
    .val_ready   (val_ready),
    .pwm_out     (pwm_out),
    .frame_start (frame_start),
    .duty_q      (duty_q)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Waits (bounded) for a frame_start sample, then samples one full period.
  task automatic measure(output int hi, output int fs, output int glitch);
    int  t;
    bit  seen_low;
    t = 0; hi = 0; fs = 0; glitch = 0; seen_low = 1'b0;
    while (!frame_start && t < 600) begin
      @(negedge clk_in);
      t++;
    end
    if (!frame_start) check("frame_start_timeout", 0, 1);
    for (int i = 0; i < PERIOD; i++) begin
      if (pwm_out) begin
        hi++;
        if (seen_low) glitch++;
      end else begin
        seen_low = 1'b1;
      end
      if (frame_start) fs++;
      @(negedge clk_in);
    end
  endtask

  task automatic measure_check(input string name, input int exp_hi);
    int hi, fs, gl;
    measure(hi, fs, gl);
    check({name, "_high"}, hi, exp_hi);
    check({name, "_frames"}, fs, 1);
    check({name, "_glitch"}, gl, 0);
  endtask

  // Presents a value and holds it until accepted; returns cycles spent waiting.
  task automatic send(input logic [VAL_W-1:0] v, output int waited);
    val_in    = v;
    val_valid = 1'b1;
    waited    = 0;
    while (!val_ready && waited < 600) begin
      @(negedge clk_in);
      waited++;
    end
    @(negedge clk_in);
    val_valid = 1'b0;
    check("accept_ready_low", int'(val_ready), 0);
  endtask

  task automatic wait_loaded();
    int t;
    t = 0;
    while (!val_ready && t < 600) begin
      @(negedge clk_in);
      t++;
    end
    check("load_ready_high", int'(val_ready), 1);
  endtask

  initial begin
    int w, w2, viol, np, exp;

    vecs[0] = '{16'h8000, 128, 128};
    vecs[1] = '{16'h4000,  64,  64};
    vecs[2] = '{16'h0000,   0,   0};
    vecs[3] = '{16'h0100,   1,   1};
    vecs[4] = '{16'hFF00, 255, 255};
    vecs[5] = '{16'h1200,  18,  18};

    rstn_in = 1'b0; enable = 1'b0; val_valid = 1'b0; val_in = '0;
    repeat (3) @(negedge clk_in);
    check("reset_pwm", int'(pwm_out), 0);
    check("reset_frame", int'(frame_start), 0);
    check("reset_duty", int'(duty_q), 0);
    check("reset_ready", int'(val_ready), 1);
    rstn_in = 1'b1;
    @(negedge clk_in);
    enable = 1'b1;

    // No input: output idle low, frame marker every period.
    measure_check("idle0", 0);
    measure_check("idle1", 0);
    check("idle_ready", int'(val_ready), 1);

    // Steady-state duty table.
    for (int i = 0; i < 6; i++) begin
      send(vecs[i].val, w);
      wait_loaded();
      measure_check($sformatf("vec%0d", i), vecs[i].exp_hi);
      check($sformatf("vec%0d_duty", i), int'(duty_q), vecs[i].exp_duty);
    end

    // Back-to-back values: second is held off until the boundary.
    send(16'h4000, w);
    send(16'hC000, w2);
    check("seq_second_held", int'(w2 > 0), 1);
    measure_check("seq_4000", 64);
    measure_check("seq_C000", 192);

    // Half-LSB residue: dither alternates, plain truncation does not.
    send(16'h8080, w);
    wait_loaded();
    for (int p = 0; p < 4; p++) begin
`ifdef PWM_DITHER_EN
      exp = (p % 2 == 1) ? 129 : 128;
`else
      exp = 128;
`endif
      measure_check($sformatf("dith8080_p%0d", p), exp);
    end

    // Asynchronous reset mid-period with the shadow occupied.
    send(16'h8000, w);
    wait_loaded();
    w = 0;
    while (!frame_start && w < 600) begin
      @(negedge clk_in);
      w++;
    end
    repeat (10) @(negedge clk_in);
    send(16'hC000, w);
    repeat (5) @(negedge clk_in);
    check("prereset_pwm", int'(pwm_out), 1);
    check("prereset_ready", int'(val_ready), 0);
    #2 rstn_in = 1'b0;
    #1;
    check("async_pwm", int'(pwm_out), 0);
    check("async_frame", int'(frame_start), 0);
    check("async_duty", int'(duty_q), 0);
    check("async_ready", int'(val_ready), 1);
    @(negedge clk_in);
    rstn_in = 1'b1;
    measure_check("postreset0", 0);
    measure_check("postreset1", 0);
    check("postreset_duty", int'(duty_q), 0);

    // Full-scale value: dither turns every carry period fully on.
    send(16'hFFFF, w);
    wait_loaded();
`ifdef PWM_DITHER_EN
    np = 257;
`else
    np = 3;
`endif
    for (int p = 0; p < np; p++) begin
`ifdef PWM_DITHER_EN
      exp = (p == 0 || p == 256) ? 255 : 256;
`else
      exp = 255;
`endif
      measure_check($sformatf("full_p%0d", p), exp);
    end

    // Idle counter while a value is loaded; first enabled period uses it.
    enable = 1'b0;
    send(16'h2000, w);
    viol = 0;
    repeat (1000) begin
      @(negedge clk_in);
      if (pwm_out || frame_start) viol++;
    end
    check("idle_outputs_low", viol, 0);
    check("idle_duty", int'(duty_q), 32);
    check("idle_ready", int'(val_ready), 1);
    enable = 1'b1;
    measure_check("enable_first", 32);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
